seg_scan_driver: RTL and testbench

//   Multiplexed 7-segment display driver. Consumes one bit of the free-running tick divider's clk_group bus
//   as its scan rate and lights one digit per scan step.

---
 rtl/seg_scan_driver.sv | 120 ++++++++++++
 tb/tb_seg_scan_driver.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver: one digit lit per scan step, hex decode with blanking,
// decimal point and leading-zero suppression; data snapshotted once per frame.
module seg_scan_driver #(
  parameter int unsigned DIGITS     = 8,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                  clk_src,
  input  logic                  rst,
  input  logic                  scan_tick,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic                  lz_suppress,
  output logic [DIGITS-1:0]     anode,
  output logic [6:0]            segs,
  output logic                  dp,
  output logic                  frame_start
);

  localparam int unsigned     IdxW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DIGITS - 1);

  logic [IdxW-1:0]     idx_q, nidx;
  logic                tick_q, step;
  logic [4*DIGITS-1:0] shadow_q, frame_data;
  logic [DIGITS-1:0]   zero_from;
  logic [DIGITS-1:0]   onehot;
  logic [3:0]          nibble;
  logic                blank_sel, dp_sel, zero_sel, dark;

  // Output registers hold active-high values; polarity is applied at the ports.
  logic [DIGITS-1:0]   anode_q, anode_d;
  logic [6:0]          segs_q, segs_d;
  logic                dp_q, dp_d, fs_q;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0:    hex7 = 7'h3F;
      4'h1:    hex7 = 7'h06;
      4'h2:    hex7 = 7'h5B;
      4'h3:    hex7 = 7'h4F;
      4'h4:    hex7 = 7'h66;
      4'h5:    hex7 = 7'h6D;
      4'h6:    hex7 = 7'h7D;
      4'h7:    hex7 = 7'h07;
      4'h8:    hex7 = 7'h7F;
      4'h9:    hex7 = 7'h6F;
      4'hA:    hex7 = 7'h77;
      4'hB:    hex7 = 7'h7C;
      4'hC:    hex7 = 7'h39;
      4'hD:    hex7 = 7'h5E;
      4'hE:    hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  always_comb begin
    step = scan_tick & ~tick_q;
    nidx = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
    // Digit 0 of a new frame must decode from the incoming data, not the stale shadow.
    frame_data = (nidx == '0) ? data : shadow_q;

    // zero_from[i]: nibbles DIGITS-1 down to i of the frame are all zero
    zero_from = '0;
    zero_from[DIGITS-1] = (frame_data[4*DIGITS-1 -: 4] == 4'h0);
    for (int i = int'(DIGITS) - 2; i >= 0; i--) begin
      zero_from[i] = zero_from[i+1] && (frame_data[4*i +: 4] == 4'h0);
    end

    onehot    = '0;
    nibble    = '0;
    blank_sel = 1'b0;
    dp_sel    = 1'b0;
    zero_sel  = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (nidx == IdxW'(i)) begin
        onehot[i] = 1'b1;
        nibble    = frame_data[4*i +: 4];
        blank_sel = blank_mask[i];
        dp_sel    = dp_mask[i];
        zero_sel  = zero_from[i];
      end
    end

    dark    = blank_sel | (lz_suppress & (nidx != '0) & zero_sel);
    anode_d = dark ? '0 : onehot;
    segs_d  = dark ? 7'h00 : hex7(nibble);
    dp_d    = ~dark & dp_sel;
  end

  always_ff @(posedge clk_src) begin
    if (rst) begin
      idx_q    <= LastIdx;
      tick_q   <= 1'b1;
      shadow_q <= '0;
      anode_q  <= '0;
      segs_q   <= '0;
      dp_q     <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      tick_q <= scan_tick;
      fs_q   <= step && (nidx == '0);
      if (step) begin
        idx_q   <= nidx;
        anode_q <= anode_d;
        segs_q  <= segs_d;
        dp_q    <= dp_d;
        if (nidx == '0) begin
          shadow_q <= data;
        end
      end
    end
  end

  assign anode       = anode_q ^ {DIGITS{ACTIVE_LOW}};
  assign segs        = segs_q ^ {7{ACTIVE_LOW}};
  assign dp          = dp_q ^ ACTIVE_LOW;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver (DIGITS=8, active-low): directed scenarios plus randomized frames
// against a reference model that snapshots frame data and decodes each digit from a table.
module tb_seg_scan_driver;

  localparam int D = 8;

  logic           clk_src = 1'b0;
  logic           rst;
  logic           scan_tick;
  logic [4*D-1:0] data;
  logic [D-1:0]   blank_mask;
  logic [D-1:0]   dp_mask;
  logic           lz_suppress;
  logic [D-1:0]   anode;
  logic [6:0]     segs;
  logic           dp;
  logic           frame_start;

  seg_scan_driver #(
    .DIGITS     (D),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk_src     (clk_src),
    .rst         (rst),
    .scan_tick   (scan_tick),
    .data        (data),
    .blank_mask  (blank_mask),
    .dp_mask     (dp_mask),
    .lz_suppress (lz_suppress),
    .anode       (anode),
    .segs        (segs),
    .dp          (dp),
    .frame_start (frame_start)
  );

  always #5 clk_src = ~clk_src;

  int n_vec = 0;
  int n_err = 0;

  logic [6:0] hex_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference state: current digit, frame snapshot, expected {anode, segs, dp, frame_start}.
  int         m_idx;
  logic [3:0] m_shadow [D];
  logic [16:0] m_exp;

  task automatic model_reset();
    m_idx = D - 1;
    for (int j = 0; j < D; j++) m_shadow[j] = 4'h0;
    m_exp = {8'hFF, 7'h7F, 1'b1, 1'b0};
  endtask

  task automatic model_step();
    int         n;
    logic [2:0] n3;
    bit         all_zero, dark;
    logic [7:0] an;
    logic [6:0] sg;
    logic       dpv;
    n  = (m_idx == D - 1) ? 0 : m_idx + 1;
    n3 = 3'(n);
    if (n == 0) begin
      for (int j = 0; j < D; j++) m_shadow[j] = 4'(data >> (4 * j));
    end
    all_zero = 1'b1;
    for (int j = n; j < D; j++) if (m_shadow[j] != 4'h0) all_zero = 1'b0;
    dark = blank_mask[n3] || (lz_suppress && n > 0 && all_zero);
    if (dark) begin
      an = 8'hFF; sg = 7'h7F; dpv = 1'b1;
    end else begin
      an  = ~(8'h01 << n);
      sg  = ~hex_tbl[m_shadow[n3]];
      dpv = ~dp_mask[n3];
    end
    m_exp = {an, sg, dpv, (n == 0)};
    m_idx = n;
  endtask

  // Low for `gap` cycles, then the edge that samples the rising level; model follows.
  task automatic apply_step(input int gap);
    scan_tick = 1'b0;
    repeat (gap) begin @(posedge clk_src); #1; end
    scan_tick = 1'b1;
    @(posedge clk_src); #1;
    model_step();
  endtask

  task automatic test_reset();
    rst = 1'b1; scan_tick = 1'b1;
    repeat (2) @(posedge clk_src);
    #1;
    model_reset();
    n_vec++;
    if ({anode, segs, dp, frame_start} !== m_exp) begin
      n_err++;
      $display("FAIL reset: got %h expected %h", {anode, segs, dp, frame_start}, m_exp);
    end
    rst = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk_src); #1;
      n_vec++;
      if ({anode, segs, dp, frame_start} !== m_exp) begin
        n_err++;
        $display("FAIL reset_release cycle %0d: got %h expected %h", c,
                 {anode, segs, dp, frame_start}, m_exp);
      end
    end
  endtask

  task automatic test_scan();
    data = 32'h01234567; blank_mask = '0; dp_mask = '0; lz_suppress = 1'b0;
    for (int s = 1; s <= 9; s++) begin
      apply_step(2);
      n_vec++;
      if ({anode, segs, dp, frame_start} !== m_exp) begin
        n_err++;
        $display("FAIL scan step %0d: got %h expected %h", s, {anode, segs, dp, frame_start}, m_exp);
      end
      if (s == 1 || s == 9) begin
        n_vec++;
        if ({anode, segs, frame_start} !== {8'hFE, 7'h78, 1'b1}) begin
          n_err++;
          $display("FAIL scan frame start step %0d: got %h expected %h", s,
                   {anode, segs, frame_start}, {8'hFE, 7'h78, 1'b1});
        end
      end
      if (s == 2) begin
        n_vec++;
        if ({anode, segs} !== {8'hFD, ~7'h7D}) begin
          n_err++;
          $display("FAIL scan step2: got %h expected %h", {anode, segs}, {8'hFD, ~7'h7D});
        end
      end
      @(posedge clk_src); #1;
      m_exp[0] = 1'b0;
      n_vec++;
      if ({anode, segs, dp, frame_start} !== m_exp) begin
        n_err++;
        $display("FAIL scan hold %0d: got %h expected %h", s, {anode, segs, dp, frame_start}, m_exp);
      end
    end
  endtask

  task automatic test_snapshot();
    while (m_idx != D - 1) apply_step(2);
    data = 32'h01234567;
    for (int s = 0; s < 2 * D; s++) begin
      if (s == 3) data = 32'hFFFFFFFF;
      apply_step(2);
      n_vec++;
      if ({anode, segs, dp, frame_start} !== m_exp) begin
        n_err++;
        $display("FAIL snapshot step %0d: got %h expected %h", s, {anode, segs, dp, frame_start}, m_exp);
      end
      if (s >= 3) begin
        n_vec++;
        if (s < D && segs !== ~hex_tbl[7 - s]) begin
          n_err++;
          $display("FAIL snapshot torn digit %0d: got %h expected %h", s, segs, ~hex_tbl[7 - s]);
        end else if (s >= D && segs !== 7'h0E) begin
          n_err++;
          $display("FAIL snapshot new frame digit %0d: got %h expected %h", s - D, segs, 7'h0E);
        end
      end
    end
  endtask

  task automatic test_lz();
    lz_suppress = 1'b1;
    for (int f = 0; f < 2; f++) begin
      data = (f == 0) ? 32'h00000A00 : 32'h0;
      for (int s = 0; s < D; s++) begin
        apply_step(2);
        n_vec++;
        if ({anode, segs, dp, frame_start} !== m_exp) begin
          n_err++;
          $display("FAIL lz frame %0d digit %0d: got %h expected %h", f, s,
                   {anode, segs, dp, frame_start}, m_exp);
        end
        if ((f == 0 && s >= 3) || (f == 1 && s >= 1)) begin
          n_vec++;
          if (anode !== 8'hFF) begin
            n_err++;
            $display("FAIL lz dark frame %0d digit %0d: got %h expected %h", f, s, anode, 8'hFF);
          end
        end
      end
    end
    lz_suppress = 1'b0;
  endtask

  task automatic test_masks();
    data = 32'h89ABCDEF; blank_mask = 8'h02; dp_mask = 8'h01;
    for (int s = 0; s < D; s++) begin
      apply_step(2);
      n_vec++;
      if ({anode, segs, dp, frame_start} !== m_exp) begin
        n_err++;
        $display("FAIL masks digit %0d: got %h expected %h", s, {anode, segs, dp, frame_start}, m_exp);
      end
      n_vec++;
      if (s == 1 && {anode, segs} !== {8'hFF, 7'h7F}) begin
        n_err++;
        $display("FAIL masks blank digit1: got %h expected %h", {anode, segs}, {8'hFF, 7'h7F});
      end else if (s != 1 && dp !== (s != 0)) begin
        n_err++;
        $display("FAIL masks dp digit %0d: got %b expected %b", s, dp, (s != 0));
      end
    end
    blank_mask = '0; dp_mask = '0;
  endtask

  task automatic test_reset_mid();
    while (m_idx != 3) apply_step(2);
    scan_tick = 1'b0;
    @(posedge clk_src); #1;
    scan_tick = 1'b1; rst = 1'b1;
    @(posedge clk_src); #1;
    model_reset();
    n_vec++;
    if ({anode, segs, dp, frame_start} !== m_exp) begin
      n_err++;
      $display("FAIL reset_mid: got %h expected %h", {anode, segs, dp, frame_start}, m_exp);
    end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk_src); #1;
      n_vec++;
      if ({anode, segs, dp, frame_start} !== m_exp) begin
        n_err++;
        $display("FAIL reset_mid hold %0d: got %h expected %h", c, {anode, segs, dp, frame_start}, m_exp);
      end
    end
    apply_step(2);
    n_vec++;
    if ({anode, frame_start} !== {8'hFE, 1'b1} || {anode, segs, dp, frame_start} !== m_exp) begin
      n_err++;
      $display("FAIL reset_mid first step: got %h expected %h", {anode, segs, dp, frame_start}, m_exp);
    end
  endtask

  task automatic test_random();
    logic [4*D-1:0] d;
    for (int s = 0; s < 300; s++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int j = 0; j < D; j++) begin
          d[4*j +: 4] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
        end
        data = d;
      end
      blank_mask  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      dp_mask     = 8'($urandom);
      lz_suppress = 1'($urandom);
      apply_step($urandom_range(1, 3));
      n_vec++;
      if ({anode, segs, dp, frame_start} !== m_exp) begin
        n_err++;
        $display("FAIL random step %0d: got %h expected %h", s, {anode, segs, dp, frame_start}, m_exp);
      end
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk_src); #1;
        m_exp[0] = 1'b0;
        n_vec++;
        if ({anode, segs, dp, frame_start} !== m_exp) begin
          n_err++;
          $display("FAIL random hold %0d: got %h expected %h", s, {anode, segs, dp, frame_start}, m_exp);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; scan_tick = 1'b1; data = '0;
    blank_mask = '0; dp_mask = '0; lz_suppress = 1'b0;
    test_reset();
    test_scan();
    test_snapshot();
    test_lz();
    test_masks();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
